// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl: APB write master that sequences one motor's PWM/H-bridge
// slave. Ramps duty toward the commanded speed at a fixed slew, forces
// zero duty plus a coast dead-time before any bridge direction change, and
// parks the motor (duty 0, bridge open) while ESTOP is held.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   S_ZERO_DUTY  | write duty=0 (after reset and on emergency stop)
//   S_ZERO_H     | write H=0000, then IDLE (or HOLD while ESTOP stays high)
//   S_IDLE       | waiting for a command, no motion pending
//   S_RAMP       | write one duty step toward the effective target
//   S_RAMP_WAIT  | slew timer between duty steps
//   S_HOFF       | write H=0000 ahead of a direction change
//   S_DEAD       | coast dead-time before enabling the new direction
//   S_HNEW       | write the new H code and adopt it as current direction
//   S_HOLD       | emergency stop parked, waits for ESTOP to drop
module motor_ramp_ctrl #(
  parameter int unsigned STEP        = 5,
  parameter int unsigned STEP_CYCLES = 20000,
  parameter int unsigned DEAD_CYCLES = 2000,
  parameter int unsigned DUTY_MAX    = 100
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [7:0]  CMD_SPEED,
  input  logic [1:0]  CMD_DIR,
  input  logic        ESTOP,
  output logic        M_PSEL,
  output logic        M_PENABLE,
  output logic        M_PWRITE,
  output logic [7:0]  M_PADDR,
  output logic [31:0] M_PWDATA,
  input  logic        M_PREADY,
  output logic        BUSY,
  output logic [7:0]  CUR_DUTY
);

  localparam logic [1:0]  DIR_COAST = 2'b00;
  localparam logic [1:0]  DIR_FWD   = 2'b01;
  localparam logic [1:0]  DIR_REV   = 2'b10;
  localparam logic [1:0]  DIR_BRAKE = 2'b11;
  localparam logic [7:0]  ADDR_DUTY = 8'h00;
  localparam logic [7:0]  ADDR_H    = 8'h04;
  localparam logic [7:0]  STEP_W    = 8'(STEP);
  localparam logic [7:0]  DMAX_W    = 8'(DUTY_MAX);
  localparam logic [31:0] STEP_LOAD = 32'(STEP_CYCLES - 1);
  localparam logic [31:0] DEAD_LOAD = 32'(DEAD_CYCLES - 1);

  typedef enum logic [3:0] {
    S_ZERO_DUTY, S_ZERO_H, S_IDLE, S_RAMP, S_RAMP_WAIT,
    S_HOFF, S_DEAD, S_HNEW, S_HOLD
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] cnt, cnt_load;
  logic        acc, gap, busy_q;
  logic [7:0]  cur_duty, tgt_speed;
  logic [1:0]  cur_dir, tgt_dir;

  logic        wr_state, psel, done, cmd_ready, accept, tc;
  logic [7:0]  spd_clamped, nt_spd, ramp_tgt, ramp_diff, ramp_step, ramp_next;
  logic [1:0]  nt_dir;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  state_t      decide;

  // Bridge pattern per direction; each half-bridge pair never sees both legs on.
  function automatic logic [3:0] hcode(input logic [1:0] dir);
    case (dir)
      DIR_FWD:   return 4'b1001;
      DIR_REV:   return 4'b0110;
      DIR_BRAKE: return 4'b1010;
      default:   return 4'b0000;
    endcase
  endfunction

  // Duty the ramp should head for: zero while a direction change is pending
  // or when the direction is coast/brake, else the commanded speed.
  function automatic logic [7:0] eff_target(input logic [1:0] dir, input logic [7:0] spd,
                                            input logic [1:0] ref_dir);
    if (dir != ref_dir || dir == DIR_COAST || dir == DIR_BRAKE) return 8'd0;
    return spd;
  endfunction

  assign wr_state    = (state == S_ZERO_DUTY) || (state == S_ZERO_H) || (state == S_RAMP) ||
                       (state == S_HOFF) || (state == S_HNEW);
  // gap forces one PSEL-low cycle after every completed transfer
  assign psel        = wr_state && !gap;
  assign done        = acc && M_PREADY;
  assign cmd_ready   = ((state == S_IDLE) || (state == S_RAMP_WAIT) || (state == S_DEAD)) && !ESTOP;
  assign accept      = CMD_VALID && cmd_ready;
  assign spd_clamped = (CMD_SPEED > DMAX_W) ? DMAX_W : CMD_SPEED;
  // decisions taken in the accept cycle already see the incoming command
  assign nt_spd      = accept ? spd_clamped : tgt_speed;
  assign nt_dir      = accept ? CMD_DIR : tgt_dir;
  assign tc          = (cnt == 32'd0);

  // Next duty step: move toward target by at most STEP, never past it.
  always_comb begin
    ramp_tgt  = eff_target(tgt_dir, tgt_speed, cur_dir);
    ramp_diff = (ramp_tgt > cur_duty) ? (ramp_tgt - cur_duty) : (cur_duty - ramp_tgt);
    ramp_step = (ramp_diff < STEP_W) ? ramp_diff : STEP_W;
    ramp_next = (ramp_tgt > cur_duty) ? (cur_duty + ramp_step) : (cur_duty - ramp_step);
  end

  // Where to go when motion may be needed (IDLE, or end of a slew period).
  always_comb begin
    decide = S_IDLE;
    if (nt_dir != cur_dir) begin
      decide = (cur_duty != 8'd0) ? S_RAMP : S_HOFF;
    end else if (cur_duty != eff_target(nt_dir, nt_spd, cur_dir)) begin
      decide = S_RAMP;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_ZERO_DUTY: if (done) state_nxt = S_ZERO_H;
      S_ZERO_H:    if (done) state_nxt = ESTOP ? S_HOLD : S_IDLE;
      S_IDLE:      state_nxt = ESTOP ? S_ZERO_DUTY : decide;
      S_RAMP: begin
        if (!psel && ESTOP) state_nxt = S_ZERO_DUTY;
        else if (done)      state_nxt = ESTOP ? S_ZERO_DUTY : S_RAMP_WAIT;
      end
      S_RAMP_WAIT: begin
        if (ESTOP)   state_nxt = S_ZERO_DUTY;
        else if (tc) state_nxt = decide;
      end
      S_HOFF: begin
        if (!psel && ESTOP) state_nxt = S_ZERO_DUTY;
        else if (done)      state_nxt = ESTOP ? S_ZERO_DUTY : S_DEAD;
      end
      S_DEAD: begin
        if (ESTOP)   state_nxt = S_ZERO_DUTY;
        else if (tc) state_nxt = S_HNEW;
      end
      S_HNEW: begin
        if (!psel && ESTOP) state_nxt = S_ZERO_DUTY;
        else if (done) begin
          if (ESTOP) state_nxt = S_ZERO_DUTY;
          else if (cur_duty != eff_target(tgt_dir, tgt_speed, tgt_dir)) state_nxt = S_RAMP;
          else state_nxt = S_IDLE;
        end
      end
      S_HOLD:      if (!ESTOP) state_nxt = S_IDLE;
      default:     state_nxt = S_ZERO_DUTY;
    endcase
  end

  // Address/data for the write owned by the current state.
  always_comb begin
    wr_addr = ADDR_DUTY;
    wr_data = 32'd0;
    case (state)
      S_ZERO_H, S_HOFF: wr_addr = ADDR_H;
      S_RAMP:           wr_data = {24'd0, ramp_next};
      S_HNEW: begin
        wr_addr = ADDR_H;
        wr_data = {28'd0, hcode(tgt_dir)};
      end
      default: ;
    endcase
  end

  // Down-counter for slew and dead-time, reloaded on every state entry.
  always_comb begin
    cnt_load = 32'd0;
    if (state_nxt == S_RAMP_WAIT) cnt_load = STEP_LOAD;
    else if (state_nxt == S_DEAD) cnt_load = DEAD_LOAD;
  end

  // State register, timer and APB phase tracking.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state  <= S_ZERO_DUTY;
      cnt    <= 32'd0;
      acc    <= 1'b0;
      gap    <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != S_IDLE);
      gap    <= done;
      if (done)              acc <= 1'b0;
      else if (psel && !acc) acc <= 1'b1;
      if (state_nxt != state) cnt <= cnt_load;
      else if (cnt != 32'd0)  cnt <= cnt - 32'd1;
    end
  end

  // Command latch, and slave-side view (duty/direction) updated on completion.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      tgt_speed <= 8'd0;
      tgt_dir   <= DIR_COAST;
      cur_duty  <= 8'd0;
      cur_dir   <= DIR_COAST;
    end else begin
      if (state_nxt == S_ZERO_DUTY && state != S_ZERO_DUTY) begin
        tgt_speed <= 8'd0;
        tgt_dir   <= DIR_COAST;
      end else if (accept) begin
        tgt_speed <= spd_clamped;
        tgt_dir   <= CMD_DIR;
      end
      if (done) begin
        case (state)
          S_RAMP:      cur_duty <= ramp_next;
          S_ZERO_DUTY: cur_duty <= 8'd0;
          S_ZERO_H:    cur_dir  <= DIR_COAST;
          S_HNEW:      cur_dir  <= tgt_dir;
          default: ;
        endcase
      end
    end
  end

  assign CMD_READY = cmd_ready;
  assign M_PSEL    = psel;
  assign M_PENABLE = acc;
  assign M_PWRITE  = psel;
  assign M_PADDR   = psel ? wr_addr : 8'd0;
  assign M_PWDATA  = psel ? wr_data : 32'd0;
  assign BUSY      = busy_q;
  assign CUR_DUTY  = cur_duty;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl with shortened slew/dead timers.
module tb_motor_ramp_ctrl;

  localparam int SC = 20;
  localparam int DC = 10;

  logic        PCLK = 1'b0;
  logic        PRESETN;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [7:0]  CMD_SPEED;
  logic [1:0]  CMD_DIR;
  logic        ESTOP;
  logic        M_PSEL, M_PENABLE, M_PWRITE;
  logic [7:0]  M_PADDR;
  logic [31:0] M_PWDATA;
  logic        M_PREADY;
  logic        BUSY;
  logic [7:0]  CUR_DUTY;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
    int          c;
  } wr_t;

  wr_t log_q[$];
  int  cyc = 0;
  int  passed = 0;
  int  total = 0;

  motor_ramp_ctrl #(.STEP(5), .STEP_CYCLES(SC), .DEAD_CYCLES(DC), .DUTY_MAX(100)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_SPEED(CMD_SPEED), .CMD_DIR(CMD_DIR),
    .ESTOP(ESTOP),
    .M_PSEL(M_PSEL), .M_PENABLE(M_PENABLE), .M_PWRITE(M_PWRITE), .M_PADDR(M_PADDR),
    .M_PWDATA(M_PWDATA), .M_PREADY(M_PREADY),
    .BUSY(BUSY), .CUR_DUTY(CUR_DUTY)
  );

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) cyc <= cyc + 1;

  // completed writes, recorded in the cycle whose closing edge completes them
  always @(negedge PCLK)
    if (M_PSEL && M_PENABLE && M_PREADY) log_q.push_back('{a: M_PADDR, d: M_PWDATA, c: cyc});

  task automatic wait_writes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge PCLK);
      if (log_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge PCLK);
      if (!BUSY) begin ok = 1'b1; break; end
    end
  endtask

  task automatic send_cmd(input logic [7:0] spd, input logic [1:0] dir,
                          output int acc_cyc, output bit ok);
    @(posedge PCLK); #1;
    CMD_VALID = 1'b1; CMD_SPEED = spd; CMD_DIR = dir;
    ok = 1'b0; acc_cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge PCLK);
      if (CMD_READY) begin ok = 1'b1; acc_cyc = cyc; break; end
    end
    @(posedge PCLK); #1;
    CMD_VALID = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    PRESETN = 1'b0; M_PREADY = 1'b1; CMD_VALID = 1'b0; CMD_SPEED = 8'd0;
    CMD_DIR = 2'b00; ESTOP = 1'b0;
    repeat (3) @(negedge PCLK);
    total++; if (M_PSEL !== 1'b0) $display("FAIL reset_psel: got %b expected 0", M_PSEL); else passed++;
    total++; if (M_PENABLE !== 1'b0) $display("FAIL reset_penable: got %b expected 0", M_PENABLE); else passed++;
    total++; if (CMD_READY !== 1'b0) $display("FAIL reset_ready: got %b expected 0", CMD_READY); else passed++;
    total++; if (BUSY !== 1'b0) $display("FAIL reset_busy: got %b expected 0", BUSY); else passed++;
    total++; if (CUR_DUTY !== 8'd0) $display("FAIL reset_duty: got %0d expected 0", CUR_DUTY); else passed++;
    @(posedge PCLK); #1;
    PRESETN = 1'b1;
    wait_writes(2, 50, ok);
    total++; if (!ok) $display("FAIL init_writes_timeout: got %0d writes expected 2", log_q.size()); else passed++;
    total++;
    if (log_q.size() < 2 || log_q[0].a !== 8'h00 || log_q[0].d !== 32'd0 || log_q[1].a !== 8'h04 || log_q[1].d !== 32'd0)
      $display("FAIL init_sequence: got %0d writes expected (00,0),(04,0)", log_q.size());
    else passed++;
    total++;
    if (log_q.size() >= 2 && log_q[1].c - log_q[0].c < 3)
      $display("FAIL init_gap: got %0d cycles expected >=3", log_q[1].c - log_q[0].c);
    else passed++;
    wait_idle(10, ok);
    total++; if (CMD_READY !== 1'b1) $display("FAIL init_ready: got %b expected 1", CMD_READY); else passed++;
  endtask

  task automatic test_ramp_up();
    logic [7:0]  ea[5];
    logic [31:0] ed[5];
    int acc_c;
    bit ok;
    ea = '{8'h04, 8'h04, 8'h00, 8'h00, 8'h00};
    ed = '{32'd0, 32'd9, 32'd5, 32'd10, 32'd12};
    log_q.delete();
    send_cmd(8'd12, 2'b01, acc_c, ok);
    total++; if (!ok) $display("FAIL fwd_accept: got no ready expected ready"); else passed++;
    wait_idle(500, ok);
    total++; if (!ok) $display("FAIL fwd_idle_timeout: got busy expected idle"); else passed++;
    total++; if (log_q.size() !== 5) $display("FAIL fwd_count: got %0d expected 5", log_q.size()); else passed++;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (i >= log_q.size() || log_q[i].a !== ea[i] || log_q[i].d !== ed[i])
        $display("FAIL fwd_write%0d: got (%0h,%0d) expected (%0h,%0d)", i,
                 (i < log_q.size()) ? log_q[i].a : 8'hxx, (i < log_q.size()) ? log_q[i].d : 32'hx, ea[i], ed[i]);
      else passed++;
    end
    if (log_q.size() == 5) begin
      total++; if (log_q[1].c - log_q[0].c !== DC + 2) $display("FAIL fwd_dead_gap: got %0d expected %0d", log_q[1].c - log_q[0].c, DC + 2); else passed++;
      total++; if (log_q[3].c - log_q[2].c !== SC + 2) $display("FAIL fwd_step_gap: got %0d expected %0d", log_q[3].c - log_q[2].c, SC + 2); else passed++;
      total++; if (log_q[4].c - log_q[3].c !== SC + 2) $display("FAIL fwd_step_gap2: got %0d expected %0d", log_q[4].c - log_q[3].c, SC + 2); else passed++;
    end
    total++; if (CUR_DUTY !== 8'd12) $display("FAIL fwd_duty: got %0d expected 12", CUR_DUTY); else passed++;
  endtask

  task automatic test_dir_change();
    logic [7:0]  ea[7];
    logic [31:0] ed[7];
    int acc_c;
    bit ok;
    ea = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h04, 8'h00, 8'h00};
    ed = '{32'd7, 32'd2, 32'd0, 32'd0, 32'd6, 32'd5, 32'd10};
    log_q.delete();
    send_cmd(8'd10, 2'b10, acc_c, ok);
    wait_idle(800, ok);
    total++; if (!ok) $display("FAIL rev_idle_timeout: got busy expected idle"); else passed++;
    total++; if (log_q.size() !== 7) $display("FAIL rev_count: got %0d expected 7", log_q.size()); else passed++;
    for (int i = 0; i < 7; i++) begin
      total++;
      if (i >= log_q.size() || log_q[i].a !== ea[i] || log_q[i].d !== ed[i])
        $display("FAIL rev_write%0d: got (%0h,%0d) expected (%0h,%0d)", i,
                 (i < log_q.size()) ? log_q[i].a : 8'hxx, (i < log_q.size()) ? log_q[i].d : 32'hx, ea[i], ed[i]);
      else passed++;
    end
    if (log_q.size() == 7) begin
      total++; if (log_q[0].c - acc_c !== 2) $display("FAIL rev_first_latency: got %0d expected 2", log_q[0].c - acc_c); else passed++;
      total++; if (log_q[4].c - log_q[3].c !== DC + 2) $display("FAIL rev_dead_gap: got %0d expected %0d", log_q[4].c - log_q[3].c, DC + 2); else passed++;
    end
    total++; if (CUR_DUTY !== 8'd10) $display("FAIL rev_duty: got %0d expected 10", CUR_DUTY); else passed++;
  endtask

  task automatic test_wait_states();
    int acc_c, pen_cycles;
    bit ok, stable, rdy_low;
    log_q.delete();
    M_PREADY = 1'b0;
    send_cmd(8'd15, 2'b10, acc_c, ok);
    pen_cycles = 0; stable = 1'b1; rdy_low = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      if (CMD_READY) rdy_low = 1'b0;
      if (M_PENABLE) begin
        pen_cycles++;
        if (!M_PSEL || M_PADDR !== 8'h00 || M_PWDATA !== 32'd15) stable = 1'b0;
        if (M_PREADY) break;
      end
      @(posedge PCLK); #1;
      if (pen_cycles == 3) M_PREADY = 1'b1;
    end
    M_PREADY = 1'b1;
    total++; if (pen_cycles !== 4) $display("FAIL ws_penable_cycles: got %0d expected 4", pen_cycles); else passed++;
    total++; if (!stable) $display("FAIL ws_stable: got changing addr/data expected stable (00,15)"); else passed++;
    total++; if (!rdy_low) $display("FAIL ws_ready: got CMD_READY=1 expected 0 during transfer"); else passed++;
    wait_idle(100, ok);
    total++;
    if (log_q.size() !== 1 || log_q[0].d !== 32'd15) $display("FAIL ws_write: got %0d writes expected one (00,15)", log_q.size());
    else passed++;
  endtask

  task automatic test_estop();
    int acc_c;
    bit ok, seen;
    send_cmd(8'd60, 2'b10, acc_c, ok);
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge PCLK);
      if (M_PSEL && !M_PENABLE && M_PWDATA == 32'd40) begin seen = 1'b1; break; end
    end
    total++; if (!seen) $display("FAIL es_reach40: got no duty-40 setup expected one"); else passed++;
    log_q.delete();
    @(posedge PCLK); #1;
    ESTOP = 1'b1;
    wait_writes(3, 50, ok);
    repeat (30) @(negedge PCLK);
    total++; if (log_q.size() !== 3) $display("FAIL es_count: got %0d expected 3", log_q.size()); else passed++;
    total++;
    if (log_q.size() < 3 || log_q[0].a !== 8'h00 || log_q[0].d !== 32'd40 || log_q[1].a !== 8'h00 ||
        log_q[1].d !== 32'd0 || log_q[2].a !== 8'h04 || log_q[2].d !== 32'd0)
      $display("FAIL es_sequence: got %0d writes expected (00,40),(00,0),(04,0)", log_q.size());
    else passed++;
    total++; if (CMD_READY !== 1'b0) $display("FAIL es_ready: got %b expected 0", CMD_READY); else passed++;
    total++; if (BUSY !== 1'b1) $display("FAIL es_busy: got %b expected 1", BUSY); else passed++;
    total++; if (CUR_DUTY !== 8'd0) $display("FAIL es_duty: got %0d expected 0", CUR_DUTY); else passed++;
    @(posedge PCLK); #1;
    ESTOP = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    total++; if (BUSY !== 1'b0) $display("FAIL es_release_busy: got %b expected 0", BUSY); else passed++;
    total++; if (CMD_READY !== 1'b1) $display("FAIL es_release_ready: got %b expected 1", CMD_READY); else passed++;
  endtask

  task automatic test_clamp_retarget();
    int acc_c;
    logic [31:0] mx;
    bit ok;
    log_q.delete();
    send_cmd(8'd200, 2'b01, acc_c, ok);
    wait_idle(2000, ok);
    total++; if (!ok) $display("FAIL clamp_idle_timeout: got busy expected idle"); else passed++;
    mx = 32'd0;
    foreach (log_q[i]) if (log_q[i].a == 8'h00 && log_q[i].d > mx) mx = log_q[i].d;
    total++; if (log_q.size() !== 22) $display("FAIL clamp_count: got %0d expected 22", log_q.size()); else passed++;
    total++; if (mx !== 32'd100) $display("FAIL clamp_max: got %0d expected 100", mx); else passed++;
    total++; if (CUR_DUTY !== 8'd100) $display("FAIL clamp_duty: got %0d expected 100", CUR_DUTY); else passed++;
    log_q.delete();
    send_cmd(8'd90, 2'b01, acc_c, ok);
    wait_writes(1, 50, ok);
    send_cmd(8'd92, 2'b01, acc_c, ok);
    total++; if (!ok) $display("FAIL retgt_accept: got no ready expected ready in slew wait"); else passed++;
    wait_idle(200, ok);
    total++;
    if (log_q.size() !== 2 || log_q[0].d !== 32'd95 || log_q[1].d !== 32'd92)
      $display("FAIL retgt_writes: got %0d writes expected (00,95),(00,92)", log_q.size());
    else passed++;
    total++; if (CUR_DUTY !== 8'd92) $display("FAIL retgt_duty: got %0d expected 92", CUR_DUTY); else passed++;
  endtask

  task automatic test_brake();
    int acc_c, n;
    bit ok;
    log_q.delete();
    send_cmd(8'd50, 2'b11, acc_c, ok);
    wait_idle(2000, ok);
    n = log_q.size();
    total++; if (n !== 21) $display("FAIL brake_count: got %0d expected 21", n); else passed++;
    total++;
    if (n < 3 || log_q[n-3].d !== 32'd0 || log_q[n-2].a !== 8'h04 || log_q[n-2].d !== 32'd0 ||
        log_q[n-1].a !== 8'h04 || log_q[n-1].d !== 32'hA)
      $display("FAIL brake_tail: got %0d writes expected ...(00,0),(04,0),(04,a)", n);
    else passed++;
    total++; if (CUR_DUTY !== 8'd0) $display("FAIL brake_duty: got %0d expected 0", CUR_DUTY); else passed++;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_dir_change();
    test_wait_states();
    test_estop();
    test_clamp_retarget();
    test_brake();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
